// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw pins and frame tick in, conditioned levels and strobes out.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic             game_tick;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_move;

    modport master (
        output btn_raw,
        output game_tick,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_move
    );

    modport slave (
        input  btn_raw,
        input  game_tick,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_move
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer, edge detector and auto-repeat move generator.
// Buttons are fully independent; every output is a flop cleared by the async reset.
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    button_conditioner_if.slave bus
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int TC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TC_W   = (TC_MAX > 1) ? $clog2(TC_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TC_W-1:0]  DELAY_LAST = TC_W'(REPEAT_DELAY - 1);
    localparam logic [TC_W-1:0]  RATE_LAST  = TC_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    logic [N_BTN-1:0] level_vec;
    logic [N_BTN-1:0] press_vec;
    logic [N_BTN-1:0] release_vec;
    logic [N_BTN-1:0] move_vec;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             s1_q;
        logic             s2_q;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        logic             move_q;
        logic             move_d;
        rep_state_e       state_q;
        rep_state_e       state_d;
        logic [TC_W-1:0]  tc_q;
        logic [TC_W-1:0]  tc_d;
        logic             rise;
        logic             fall;

        // A new level is accepted only after DEBOUNCE_CYCLES consecutive
        // disagreeing samples; any agreeing sample restarts the count.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = cnt_q;
            if (s2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        assign rise      = stable_d & ~stable_q;
        assign fall      = ~stable_d & stable_q;
        assign press_d   = rise;
        assign release_d = fall;

        // Edges are taken from the debouncer's next state so press, move and
        // the new level all land on the same clock edge. Release beats a tick;
        // a press swallows a coincident tick.
        always_comb begin
            state_d = state_q;
            tc_d    = tc_q;
            move_d  = 1'b0;
            if (fall) begin
                state_d = IDLE;
                tc_d    = '0;
            end else if (rise) begin
                state_d = DELAY;
                tc_d    = '0;
                move_d  = 1'b1;
            end else if (bus.game_tick) begin
                case (state_q)
                    DELAY: begin
                        if (tc_q == DELAY_LAST) begin
                            state_d = REPEAT;
                            tc_d    = '0;
                            move_d  = 1'b1;
                        end else begin
                            tc_d = tc_q + TC_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (tc_q == RATE_LAST) begin
                            tc_d   = '0;
                            move_d = 1'b1;
                        end else begin
                            tc_d = tc_q + TC_W'(1);
                        end
                    end
                    default: begin
                        tc_d = tc_q;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                stable_q  <= 1'b0;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                move_q    <= 1'b0;
                state_q   <= IDLE;
                tc_q      <= '0;
            end else begin
                s1_q      <= bus.btn_raw[i];
                s2_q      <= s1_q;
                stable_q  <= stable_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                move_q    <= move_d;
                state_q   <= state_d;
                tc_q      <= tc_d;
            end
        end

        assign level_vec[i]   = stable_q;
        assign press_vec[i]   = press_q;
        assign release_vec[i] = release_q;
        assign move_vec[i]    = move_q;
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_press   = press_vec;
    assign bus.btn_release = release_vec;
    assign bus.btn_move    = move_vec;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Debounces, synchronises and edge-detects the raw push-button inputs, then turns each held button into game-rate move pulses with auto-repeat. It sits between the board button pins and the game-logic update process. Game logic consumes the one-cycle `btn_move` strobes instead of sampling raw levels on the 60 Hz tick. Bounce, metastability and double-stepping are all handled here.

## Interface
Parameters:
- `N_BTN`, default 4: number of buttons handled, with identical per-button logic.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive `clk` cycles a new level must persist before it is accepted. Legal range is ≥ 2.
- `REPEAT_DELAY`, default 20: `game_tick` strobes between a press and the first auto-repeat. Legal range is ≥ 1.
- `REPEAT_RATE`, default 4: `game_tick` strobes between subsequent auto-repeats. Legal range is ≥ 1.

Ports:
- `clk`, in, 1: system clock; sole clock of the block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_raw`, in, `N_BTN`: raw, asynchronous, bouncing button pins; active high.
- `game_tick`, in, 1: one-`clk`-cycle strobe per game frame, synchronous to `clk`.
- `btn_level`, out, `N_BTN`: debounced button level.
- `btn_press`, out, `N_BTN`: one-cycle strobe on a debounced rising edge.
- `btn_release`, out, `N_BTN`: one-cycle strobe on a debounced falling edge.
- `btn_move`, out, `N_BTN`: one-cycle strobe, once per press plus auto-repeats while held.

## Operation
Each button is processed independently. There is no cross-button interaction.

- **Synchroniser:** two flops, `s1 <= btn_raw[i]` and `s2 <= s1`. Both reset to 0.
- **Debounce:**
  - `stable` (reset 0) and a counter `cnt` (reset 0), sized to hold `DEBOUNCE_CYCLES-1`.
  - If `s2 == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any single-cycle return to `stable` restarts the count from 0.
- **Level and edge outputs:**
  - `btn_level = stable`.
  - `btn_press` and `btn_release` are registered. They assert in the cycle immediately after the edge at which `stable` changes, i.e. together with the new `btn_level`, and stay high for exactly one cycle.
- **Repeat FSM:** per-button states IDLE, DELAY and REPEAT, plus a tick counter `tc` (reset 0) wide enough for max(`REPEAT_DELAY`, `REPEAT_RATE`).
  - **IDLE:** when `stable` rises, go to DELAY, set `tc <= 0` and assert `btn_move` (coincident with `btn_press`).
  - **DELAY:** on each `game_tick`, `tc <= tc+1`. On the tick where `tc == REPEAT_DELAY-1`, assert `btn_move`, go to REPEAT and set `tc <= 0`.
  - **REPEAT:** on each `game_tick`, `tc <= tc+1`. On the tick where `tc == REPEAT_RATE-1`, assert `btn_move` and set `tc <= 0`.
  - **Any state:** when `stable` falls, go to IDLE and set `tc <= 0`. No `btn_move` is issued.
- **Simultaneous events:**
  - A fall of `stable` in the same cycle as `game_tick`: the release wins. No move pulse, `tc` is cleared.
  - A rise of `stable` coinciding with `game_tick`: the tick is not counted, and the press produces exactly one `btn_move`.
- **Counter behaviour:** `tc` cannot overflow because it is cleared on match. `cnt` never exceeds `DEBOUNCE_CYCLES-1`.
- **Reset:** at reset, all outputs are 0, all FSMs are in IDLE, and all counters are 0. Reset mid-operation aborts immediately. A button held through reset release produces a fresh press after the full debounce latency.

## Timing
- **Press latency:** with `btn_raw` high and clean from before edge 0, `btn_level`, `btn_press` and `btn_move` are high after edge `DEBOUNCE_CYCLES+1`. That is 2 synchroniser cycles plus `DEBOUNCE_CYCLES` counted cycles, `DEBOUNCE_CYCLES+2` edges in total. Release latency is identical.
- **First repeat:** `btn_move` pulses in the cycle after the edge that samples the `REPEAT_DELAY`-th `game_tick` following the press.
- **Later repeats:** every `REPEAT_RATE` ticks thereafter. Each pulse trails its `game_tick` by exactly 1 cycle.
- All outputs are registered, and all strobes are exactly 1 `clk` cycle wide.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=3` and `REPEAT_RATE=2`, with `game_tick` every 10 cycles.

- **Reset:** assert `rst_n=0` mid-cycle with `btn_raw=4'b1111` -> all outputs are 0 immediately. After release, `btn_level=4'b1111` appears 6 edges later, with exactly one `btn_press` and one `btn_move` per button.
- **Bounce rejection:** `btn_raw[0]` toggles with high-runs of 3 cycles and low-runs of 1 cycle, 5 times -> no `btn_press[0]`. It then holds high -> `btn_press[0]` after 6 edges, exactly once.
- **Auto-repeat:** hold `btn_raw[1]` for 100 cycles -> `btn_move[1]` pulses once at press, then 1 cycle after the 3rd tick, then 1 cycle after every 2nd tick. All pulses are 1 cycle wide.
- **Release/tick collision:** `stable` falls in the same cycle as `game_tick` -> `btn_release=1`, no `btn_move`. A re-press restarts with a full `REPEAT_DELAY`.
- **Independence:** press `b0` and `b3` with a 2-cycle offset -> their strobes are offset by exactly 2 cycles, and `b1`/`b2` outputs stay 0.
- **Short hold:** hold for 20 cycles (fewer than 3 ticks), then release -> exactly one `btn_move`, one `btn_press` and one `btn_release`.
